uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx instance (en/data_in/rdy handshake) between two byte streams: the
//  forwarded board stream (uart_rx valid/data pulses) and PC-injected bytes.
//  Each stream is buffered in its own FIFO, so bytes are no longer lost while the transmitter is busy.
//  Sits between the uart_rx outputs and the uart_tx input in the MITM top level.
// PARAMETERS
//  FIFO_DEPTH    8   entries per channel FIFO; power of 2, >=2
//  BUSY_TIMEOUT  4   cycles to wait for tx_rdy to drop after tx_en before returning to IDLE
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-low reset
//  fwd_valid  in   1   1-cycle pulse: fwd_data valid (forwarded stream)
//  fwd_data   in   8   forwarded byte
//  pc_valid   in   1   1-cycle pulse: pc_data valid (injected stream)
//  pc_data    in   8   injected byte
//  fwd_mute   in   1   1 = discard forwarded stream (override mode)
//  tx_rdy     in   1   uart_tx idle/ready
//  tx_en      out  1   1-cycle start strobe to uart_tx
//  tx_data    out  8   byte to uart_tx; stable from ISSUE until next pop
//  grant_pc   out  1   source of the current tx_data: 1 = PC, 0 = fwd
//  fwd_level  out  L   fwd FIFO occupancy, L = $clog2(FIFO_DEPTH+1)
//  pc_level   out  L   PC FIFO occupancy
//  fwd_drops  out  8   saturating count of fwd bytes lost to overflow
//  pc_drops   out  8   saturating count of PC bytes lost to overflow
// BEHAVIOUR
//  Reset values: tx_en=0, tx_data=0, grant_pc=0, levels=0, drops=0, FSM=IDLE, last_grant=PC.
//  FIFO push: on valid && !full. Push when full without a same-cycle pop: byte dropped, drops+1, sat at 255.
//  Push+pop on a full FIFO in the same cycle: both succeed; level unchanged; no drop.
//  Push+pop on an empty FIFO in the same cycle: push only; the byte is poppable next cycle.
//  fwd_mute=1: fwd FIFO flushed every cycle (level->0); fwd_valid ignored, not counted as a drop.
//    A fwd byte already popped into tx_data is still transmitted.
//  FSM:
//   IDLE:   if tx_rdy && any FIFO non-empty: select channel, pop head into tx_data,
//           set grant_pc and last_grant, go ISSUE. Otherwise stay.
//   ISSUE:  tx_en=1 for exactly this cycle; go WAIT_BUSY.
//   WAIT_BUSY: go IDLE when tx_rdy==0 is seen, or after BUSY_TIMEOUT cycles with tx_rdy still 1.
//     IDLE then waits for tx_rdy==1. tx_en is never asserted while tx_rdy==0.
//  Arbitration (round-robin):
//   - Both channels non-empty: grant the channel not in last_grant.
//   - One channel non-empty: grant that channel.
//  Latency: valid pulse at cycle N into an empty FIFO, FSM in IDLE, tx_rdy=1 -> tx_en at N+2.
//  Ordering within a channel is strict FIFO. Back-to-back throughput is one byte per uart_tx frame.
//  Async reset mid-frame: FIFOs and counters cleared immediately; any pending byte is lost.
// CONFIGURATION
//  ARB_PC_PRIORITY_EN defined: strict priority; PC channel always wins when non-empty,
//    and fwd is served only when the PC FIFO is empty.
//  Not defined: round-robin as above.
// TESTING
//  1 reset, tx_rdy=1, fwd_valid 0x41 -> tx_en exactly 2 cycles later, tx_data=0x41, grant_pc=0.
//  2 tx_rdy=0, fwd 0x01..0x04 and pc 0xA1..0xA4 queued, then model uart_tx
//    -> order 01,A1,02,A2,03,A3,04,A4; with ARB_PC_PRIORITY_EN -> A1..A4 then 01..04.
//  3 tx_rdy held 0, 10 fwd bytes at DEPTH=8 -> fwd_level=8, fwd_drops=2; release -> first 8 bytes sent in order.
//  4 300 overflow pushes -> fwd_drops saturates at 255, no wrap.
//  5 fwd_mute=1 with 3 queued and 1 in tx_data -> level 0, only the latched byte is sent;
//    new fwd bytes while muted are not sent and not counted.
//  6 tx_rdy stuck at 1 after tx_en -> IDLE after BUSY_TIMEOUT=4 cycles;
//    rst low in WAIT_BUSY -> all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-channel (forwarded / PC-injected) byte arbiter feeding a single uart_tx, with per-channel FIFOs.
// Optional macro ARB_PC_PRIORITY_EN: strict PC priority instead of round-robin.

module uart_tx_arbiter_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic [7:0]                     din,
  input  logic                           pop,
  output logic [7:0]                     head,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic [7:0]                     drops
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;
  logic          drop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == {LW{1'b0}});
  assign do_pop  = pop && !empty && !flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);
  assign drop    = push && !flush && full && !do_pop;
  assign head    = mem[rd_ptr];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      level  <= {LW{1'b0}};
      drops  <= 8'd0;
    end else if (flush) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      level  <= {LW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop && (drops != 8'hFF)) begin
        drops <= drops + 8'd1;
      end
    end
  end
endmodule

module uart_tx_arbiter #(
  parameter int FIFO_DEPTH   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fwd_valid,
  input  logic [7:0]                        fwd_data,
  input  logic                              pc_valid,
  input  logic [7:0]                        pc_data,
  input  logic                              fwd_mute,
  input  logic                              tx_rdy,
  output logic                              tx_en,
  output logic [7:0]                        tx_data,
  output logic                              grant_pc,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fwd_level,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   pc_level,
  output logic [7:0]                        fwd_drops,
  output logic [7:0]                        pc_drops
);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY} state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic          last_grant;
  logic          fwd_avail;
  logic          pc_avail;
  logic          sel_pc;
  logic          pop_fwd;
  logic          pop_pc;
  logic [7:0]    fwd_head;
  logic [7:0]    pc_head;

  uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fwd_fifo (
    .clk(clk), .rst(rst), .flush(fwd_mute), .push(fwd_valid), .din(fwd_data),
    .pop(pop_fwd), .head(fwd_head), .level(fwd_level), .drops(fwd_drops)
  );

  uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_fifo (
    .clk(clk), .rst(rst), .flush(1'b0), .push(pc_valid), .din(pc_data),
    .pop(pop_pc), .head(pc_head), .level(pc_level), .drops(pc_drops)
  );

  // A muted forwarded channel is never eligible, even in the cycle mute rises.
  assign fwd_avail = !fwd_mute && (fwd_level != {LW{1'b0}});
  assign pc_avail  = (pc_level != {LW{1'b0}});

  // Channel selection.
  always_comb begin
    sel_pc = 1'b0;
`ifdef ARB_PC_PRIORITY_EN
    sel_pc = pc_avail;
`else
    if (pc_avail && fwd_avail) begin
      sel_pc = !last_grant;
    end else begin
      sel_pc = pc_avail;
    end
`endif
  end

  // Next-state and FIFO pop decode.
  always_comb begin
    next_state = state;
    pop_fwd    = 1'b0;
    pop_pc     = 1'b0;
    case (state)
      IDLE: begin
        if (tx_rdy && (fwd_avail || pc_avail)) begin
          next_state = ISSUE;
          if (sel_pc) begin
            pop_pc = 1'b1;
          end else begin
            pop_fwd = 1'b1;
          end
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE: next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!tx_rdy) begin
          next_state = IDLE;
        end else if (wait_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          next_state = IDLE;
        end else begin
          next_state = WAIT_BUSY;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, timeout counter and registered tx outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= {CW{1'b0}};
      tx_en      <= 1'b0;
      tx_data    <= 8'h00;
      grant_pc   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state    <= next_state;
      wait_cnt <= (state == WAIT_BUSY) ? wait_cnt + 1'b1 : {CW{1'b0}};
      tx_en    <= (next_state == ISSUE);
      if (pop_fwd || pop_pc) begin
        tx_data    <= pop_pc ? pc_head : fwd_head;
        grant_pc   <= pop_pc;
        last_grant <= pop_pc;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (FIFO_DEPTH=8, BUSY_TIMEOUT=4).
module tb_uart_tx_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fwd_valid = 1'b0;
  logic [7:0] fwd_data = 8'h00;
  logic       pc_valid = 1'b0;
  logic [7:0] pc_data = 8'h00;
  logic       fwd_mute = 1'b0;
  logic       tx_rdy = 1'b0;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       grant_pc;
  logic [3:0] fwd_level;
  logic [3:0] pc_level;
  logic [7:0] fwd_drops;
  logic [7:0] pc_drops;

  int checks = 0;
  int errors = 0;
  logic [7:0] got_data[$];
  logic       got_pc[$];
  logic [7:0] exp_seq[8];

  uart_tx_arbiter #(.FIFO_DEPTH(8), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
    .pc_valid(pc_valid), .pc_data(pc_data), .fwd_mute(fwd_mute), .tx_rdy(tx_rdy),
    .tx_en(tx_en), .tx_data(tx_data), .grant_pc(grant_pc),
    .fwd_level(fwd_level), .pc_level(pc_level), .fwd_drops(fwd_drops), .pc_drops(pc_drops)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task apply_reset;
    rst = 1'b0; fwd_valid = 1'b0; pc_valid = 1'b0; fwd_mute = 1'b0; tx_rdy = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
  endtask

  // Model of uart_tx: on each tx_en, record the byte and hold rdy low for frame cycles.
  task run_uart(input int n, input int frame);
    int cyc;
    int low;
    cyc = 0; low = 0;
    got_data.delete(); got_pc.delete();
    tx_rdy = 1'b1;
    while (got_data.size() < n && cyc < 2000) begin
      if (tx_en) begin
        got_data.push_back(tx_data); got_pc.push_back(grant_pc);
        tx_rdy = 1'b0; low = frame;
      end else if (low > 0) begin
        low--;
        if (low == 0) tx_rdy = 1'b1;
      end
      tick; cyc++;
    end
    checks++;
    if (got_data.size() != n) begin
      errors++; $display("FAIL uart_timeout: got %0d bytes, expected %0d", got_data.size(), n);
    end
  endtask

  task test_reset;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_en, tx_data, grant_pc, fwd_level, pc_level, fwd_drops, pc_drops} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs: got en=%0b data=%h g=%0b fl=%0d pl=%0d fd=%0d pd=%0d, expected all 0",
                         tx_en, tx_data, grant_pc, fwd_level, pc_level, fwd_drops, pc_drops);
    end
    rst = 1'b1;
    tick;
  endtask

  task test_latency;
    tx_rdy = 1'b1;
    fwd_valid = 1'b1; fwd_data = 8'h41;
    tick;
    fwd_valid = 1'b0;
    checks++;
    if (tx_en !== 1'b0 || fwd_level !== 4'd1) begin
      errors++; $display("FAIL lat_n1: got en=%0b level=%0d, expected en=0 level=1", tx_en, fwd_level);
    end
    tick;
    checks++;
    if (tx_en !== 1'b1 || tx_data !== 8'h41 || grant_pc !== 1'b0 || fwd_level !== 4'd0) begin
      errors++; $display("FAIL lat_n2: got en=%0b data=%h g=%0b level=%0d, expected 1 41 0 0",
                         tx_en, tx_data, grant_pc, fwd_level);
    end
    tick;
    checks++;
    if (tx_en !== 1'b0) begin
      errors++; $display("FAIL lat_single_pulse: got en=%0b, expected 0", tx_en);
    end
  endtask

  task test_arbitration;
    apply_reset;
    for (int i = 0; i < 4; i++) begin
      fwd_valid = 1'b1; fwd_data = 8'h01 + 8'(i);
      pc_valid = 1'b1;  pc_data = 8'hA1 + 8'(i);
      tick;
    end
    fwd_valid = 1'b0; pc_valid = 1'b0;
    checks++;
    if (fwd_level !== 4'd4 || pc_level !== 4'd4) begin
      errors++; $display("FAIL arb_levels: got fwd=%0d pc=%0d, expected 4 4", fwd_level, pc_level);
    end
`ifdef ARB_PC_PRIORITY_EN
    exp_seq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h01, 8'h02, 8'h03, 8'h04};
`else
    exp_seq = '{8'h01, 8'hA1, 8'h02, 8'hA2, 8'h03, 8'hA3, 8'h04, 8'hA4};
`endif
    run_uart(8, 3);
    for (int i = 0; i < got_data.size() && i < 8; i++) begin
      checks++;
      if (got_data[i] !== exp_seq[i] || got_pc[i] !== exp_seq[i][7]) begin
        errors++; $display("FAIL arb_order[%0d]: got %h g=%0b, expected %h g=%0b",
                           i, got_data[i], got_pc[i], exp_seq[i], exp_seq[i][7]);
      end
    end
  endtask

  task test_overflow;
    int extra;
    apply_reset;
    for (int i = 0; i < 10; i++) begin
      fwd_valid = 1'b1; fwd_data = 8'h10 + 8'(i);
      tick;
    end
    fwd_valid = 1'b0;
    checks++;
    if (fwd_level !== 4'd8 || fwd_drops !== 8'd2) begin
      errors++; $display("FAIL ovf_count: got level=%0d drops=%0d, expected 8 2", fwd_level, fwd_drops);
    end
    // Pop and push collide on a full FIFO: both succeed.
    tx_rdy = 1'b1; fwd_valid = 1'b1; fwd_data = 8'h1A;
    tick;
    fwd_valid = 1'b0;
    checks++;
    if (fwd_level !== 4'd8 || fwd_drops !== 8'd2 || tx_en !== 1'b1 || tx_data !== 8'h10) begin
      errors++; $display("FAIL full_push_pop: got level=%0d drops=%0d en=%0b data=%h, expected 8 2 1 10",
                         fwd_level, fwd_drops, tx_en, tx_data);
    end
    run_uart(9, 2);
    for (int i = 0; i < got_data.size() && i < 9; i++) begin
      checks++;
      if (got_data[i] !== ((i == 8) ? 8'h1A : 8'h10 + 8'(i))) begin
        errors++; $display("FAIL ovf_order[%0d]: got %h, expected %h",
                           i, got_data[i], (i == 8) ? 8'h1A : 8'h10 + 8'(i));
      end
    end
    tx_rdy = 1'b1;
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (tx_en) extra++;
    end
    checks++;
    if (extra != 0 || fwd_level !== 4'd0) begin
      errors++; $display("FAIL ovf_drained: got extra=%0d level=%0d, expected 0 0", extra, fwd_level);
    end
  endtask

  task test_saturation;
    apply_reset;
    for (int i = 0; i < 300; i++) begin
      fwd_valid = 1'b1; fwd_data = 8'(i);
      pc_valid = (i < 9); pc_data = 8'(i);
      tick;
    end
    fwd_valid = 1'b0; pc_valid = 1'b0;
    checks++;
    if (fwd_drops !== 8'd255 || fwd_level !== 4'd8) begin
      errors++; $display("FAIL drop_saturate: got drops=%0d level=%0d, expected 255 8", fwd_drops, fwd_level);
    end
    checks++;
    if (pc_drops !== 8'd1 || pc_level !== 4'd8) begin
      errors++; $display("FAIL pc_drop: got drops=%0d level=%0d, expected 1 8", pc_drops, pc_level);
    end
  endtask

  task test_mute;
    int sent;
    apply_reset;
    for (int i = 0; i < 4; i++) begin
      fwd_valid = 1'b1; fwd_data = 8'h51 + 8'(i);
      tick;
    end
    fwd_valid = 1'b0;
    tx_rdy = 1'b1;
    tick;
    checks++;
    if (tx_en !== 1'b1 || tx_data !== 8'h51 || fwd_level !== 4'd3) begin
      errors++; $display("FAIL mute_latched: got en=%0b data=%h level=%0d, expected 1 51 3", tx_en, tx_data, fwd_level);
    end
    tx_rdy = 1'b0; fwd_mute = 1'b1; fwd_valid = 1'b1; fwd_data = 8'h5A;
    tick;
    fwd_valid = 1'b0;
    checks++;
    if (fwd_level !== 4'd0) begin
      errors++; $display("FAIL mute_flush: got level=%0d, expected 0", fwd_level);
    end
    tick; tick;
    tx_rdy = 1'b1;
    sent = 0;
    for (int i = 0; i < 20; i++) begin
      fwd_valid = (i == 5); fwd_data = 8'h5B;
      tick;
      if (tx_en) sent++;
    end
    fwd_valid = 1'b0;
    checks++;
    if (sent != 0 || fwd_drops !== 8'd0 || fwd_level !== 4'd0) begin
      errors++; $display("FAIL mute_no_send: got sent=%0d drops=%0d level=%0d, expected 0 0 0", sent, fwd_drops, fwd_level);
    end
    fwd_mute = 1'b0;
  endtask

  task test_timeout_and_reset;
    int k;
    int sent;
    apply_reset;
    tx_rdy = 1'b1;
    fwd_valid = 1'b1; fwd_data = 8'h61;
    tick;
    fwd_valid = 1'b0; pc_valid = 1'b1; pc_data = 8'h62;
    tick;
    pc_valid = 1'b0;
    checks++;
    if (tx_en !== 1'b1 || tx_data !== 8'h61) begin
      errors++; $display("FAIL to_first: got en=%0b data=%h, expected 1 61", tx_en, tx_data);
    end
    k = 0;
    do begin
      tick; k++;
    end while (!tx_en && k < 20);
    checks++;
    if (k != 6 || tx_data !== 8'h62 || grant_pc !== 1'b1) begin
      errors++; $display("FAIL busy_timeout: got gap=%0d data=%h g=%0b, expected 6 62 1", k, tx_data, grant_pc);
    end
    pc_valid = 1'b1; pc_data = 8'h71;
    tick;
    pc_valid = 1'b0;
    checks++;
    if (pc_level !== 4'd1) begin
      errors++; $display("FAIL pending_pc: got level=%0d, expected 1", pc_level);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({tx_en, tx_data, grant_pc, fwd_level, pc_level, fwd_drops, pc_drops} !== 34'd0) begin
      errors++; $display("FAIL async_reset: got en=%0b data=%h g=%0b fl=%0d pl=%0d, expected all 0",
                         tx_en, tx_data, grant_pc, fwd_level, pc_level);
    end
    @(negedge clk);
    rst = 1'b1;
    sent = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (tx_en) sent++;
    end
    checks++;
    if (sent != 0) begin
      errors++; $display("FAIL reset_lost_byte: got sent=%0d, expected 0", sent);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_arbitration;
    test_overflow;
    test_saturation;
    test_mute;
    test_timeout_and_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
